// File: rtl/stm32_bus_interface.sv
// STM32 parallel-bus slave: command decode, parameter/status/IQ beat shifting, RX sample FIFO.
// Define STM32_IF_PARITY_EN to add an XOR parity beat to RXIQ/TXIQ transfers and the SENDP parity flag.
module stm32_bus_interface #(
  parameter int BUS_W      = 4,
  parameter int IQ_W       = 16,
  parameter int RX_CH      = 1,
  parameter int FREQ_W     = 22,
  parameter int FREQ_RESET = 620407,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_in,
  input  logic                          reset,
  input  logic [BUS_W-1:0]              DATA_IN,
  input  logic                          DATA_SYNC,
  input  logic                          ADC_OTR,
  input  logic [RX_CH*IQ_W-1:0]         rx_i,
  input  logic [RX_CH*IQ_W-1:0]         rx_q,
  input  logic                          iq_valid,
  output logic [BUS_W-1:0]              DATA_OUT,
  output logic [FREQ_W-1:0]             freq_out,
  output logic                          preamp_enable,
  output logic                          rx,
  output logic                          tx,
  output logic                          audio_clk_en,
  output logic signed [IQ_W-1:0]        TX_I,
  output logic signed [IQ_W-1:0]        TX_Q,
  output logic                          tx_iq_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    stage_debug
);
  // state | meaning
  // IDLE  | waiting for a DATA_SYNC command
  // GETP  | control beat + frequency beats in, committed atomically
  // SENDP | one status beat out, read flags cleared
  // TXIQ  | Q then I beats in (+ parity), loaded together
  // RXIQ  | FIFO pop, channel Q/I beats out (+ parity)
  // TEST  | DATA_IN echoed to DATA_OUT for 4 beats
  typedef enum logic [3:0] {S_IDLE = 4'd0, S_GETP, S_SENDP, S_TXIQ, S_RXIQ, S_TEST} state_t;

  localparam int NF    = (FREQ_W + BUS_W - 1) / BUS_W;
  localparam int TX_W  = 2 * IQ_W;
  localparam int RX_W  = 2 * RX_CH * IQ_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
`ifdef STM32_IF_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam logic [7:0] GETP_LAST = 8'(NF);
  localparam logic [7:0] TX_DLAST  = 8'(TX_W / BUS_W - 1);
  localparam logic [7:0] RX_DLAST  = 8'(RX_W / BUS_W - 1);
  localparam logic [7:0] TX_LAST   = TX_DLAST + 8'(PAR_EN);
  localparam logic [7:0] RX_LAST   = RX_DLAST + 8'(PAR_EN);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  state_t            state;
  logic [7:0]        beat;
  logic [1:0]        ctrl_sh;
  logic [FREQ_W-1:0] freq_sh, freq_next;
  logic [TX_W-1:0]   tx_sh, tx_word;
  logic [BUS_W-1:0]  tx_par, rx_par, status_word;
  logic [RX_W-1:0]   rx_sh, rx_word, pop_word;
  logic              otr_flag, ovr_flag, unr_flag, perr_flag;

  logic [RX_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  count;
  logic fifo_empty, fifo_full, pop_req, do_pop, do_push, ovr_ev, unr_ev, perr_ev, status_rd;

  // Host word order is ch0 Q, ch0 I, ch1 Q, ... from the MSB down.
  always_comb begin
    rx_word = '0;
    for (int n = 0; n < RX_CH; n++) begin
      rx_word[RX_W-1-2*n*IQ_W -: IQ_W]     = rx_q[n*IQ_W +: IQ_W];
      rx_word[RX_W-1-(2*n+1)*IQ_W -: IQ_W] = rx_i[n*IQ_W +: IQ_W];
    end
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_LVL);
  assign pop_req    = (state == S_RXIQ) && (beat == 8'd0) && !DATA_SYNC;
  assign do_pop     = pop_req && !fifo_empty;
  assign do_push    = iq_valid && (!fifo_full || do_pop);
  assign ovr_ev     = iq_valid && fifo_full && !do_pop;
  assign unr_ev     = pop_req && fifo_empty;
  assign pop_word   = do_pop ? fifo_mem[rd_ptr] : '0;
  assign status_rd  = (state == S_SENDP) && (beat == 8'd0) && !DATA_SYNC;
  assign perr_ev    = PAR_EN && (state == S_TXIQ) && (beat == TX_LAST) && !DATA_SYNC
                      && (DATA_IN != tx_par);
  assign freq_next  = FREQ_W'({freq_sh, DATA_IN});
  assign tx_word    = TX_W'({tx_sh, DATA_IN});
  assign fifo_level = count;
  assign stage_debug = {state, beat[3:0]};

  always_comb begin
    status_word    = '0;
    status_word[0] = otr_flag;
    status_word[1] = ovr_flag;
    status_word[2] = unr_flag;
    status_word[3] = PAR_EN & perr_flag;
  end

  always_ff @(posedge clk_in) begin
    if (do_push) fifo_mem[wr_ptr] <= rx_word;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      otr_flag <= 1'b0;
      ovr_flag <= 1'b0;
      unr_flag <= 1'b0;
      perr_flag <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A flag set in the same cycle it is read stays set for the next read.
      otr_flag  <= ADC_OTR | (otr_flag & ~status_rd);
      ovr_flag  <= ovr_ev  | (ovr_flag & ~status_rd);
      unr_flag  <= unr_ev  | (unr_flag & ~status_rd);
      perr_flag <= perr_ev | (perr_flag & ~status_rd);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= S_IDLE;
      beat <= '0;
      ctrl_sh <= '0;
      freq_sh <= '0;
      tx_sh <= '0;
      tx_par <= '0;
      rx_sh <= '0;
      rx_par <= '0;
      DATA_OUT <= '0;
      freq_out <= FREQ_W'(FREQ_RESET);
      preamp_enable <= 1'b0;
      rx <= 1'b1;
      tx <= 1'b0;
      audio_clk_en <= 1'b0;
      TX_I <= '0;
      TX_Q <= '0;
      tx_iq_valid <= 1'b0;
    end else begin
      tx_iq_valid <= 1'b0;
      if (DATA_SYNC) begin
        beat <= '0;
        case (DATA_IN[3:0])
          4'd1:    state <= S_GETP;
          4'd2:    state <= S_SENDP;
          4'd3:    state <= S_TXIQ;
          4'd4:    state <= S_RXIQ;
          4'd10:   state <= S_TEST;
          4'd5:    begin audio_clk_en <= 1'b1; state <= S_IDLE; end
          4'd6:    begin audio_clk_en <= 1'b0; state <= S_IDLE; end
          default: state <= S_IDLE;
        endcase
      end else begin
        case (state)
          S_GETP: begin
            if (beat == 8'd0) ctrl_sh <= DATA_IN[3:2];
            else              freq_sh <= freq_next;
            if (beat == GETP_LAST) begin
              freq_out      <= freq_next;
              preamp_enable <= ctrl_sh[0];
              tx            <= ctrl_sh[1];
              rx            <= ~ctrl_sh[1];
              state <= S_IDLE;
              beat  <= '0;
            end else beat <= beat + 8'd1;
          end
          S_SENDP: begin
            DATA_OUT <= status_word;
            state <= S_IDLE;
          end
          S_TXIQ: begin
            if (beat <= TX_DLAST) begin
              tx_sh  <= tx_word;
              tx_par <= ((beat == 8'd0) ? '0 : tx_par) ^ DATA_IN;
            end
            if (beat == TX_LAST) begin
              if (!PAR_EN) begin
                TX_Q <= tx_word[TX_W-1 -: IQ_W];
                TX_I <= tx_word[IQ_W-1:0];
                tx_iq_valid <= 1'b1;
              end else if (DATA_IN == tx_par) begin
                TX_Q <= tx_sh[TX_W-1 -: IQ_W];
                TX_I <= tx_sh[IQ_W-1:0];
                tx_iq_valid <= 1'b1;
              end
              state <= S_IDLE;
              beat  <= '0;
            end else beat <= beat + 8'd1;
          end
          S_RXIQ: begin
            if (beat == 8'd0) begin
              DATA_OUT <= pop_word[RX_W-1 -: BUS_W];
              rx_par   <= pop_word[RX_W-1 -: BUS_W];
              rx_sh    <= pop_word << BUS_W;
            end else if (beat <= RX_DLAST) begin
              DATA_OUT <= rx_sh[RX_W-1 -: BUS_W];
              rx_par   <= rx_par ^ rx_sh[RX_W-1 -: BUS_W];
              rx_sh    <= rx_sh << BUS_W;
            end else begin
              DATA_OUT <= rx_par;
            end
            if (beat == RX_LAST) begin
              state <= S_IDLE;
              beat  <= '0;
            end else beat <= beat + 8'd1;
          end
          S_TEST: begin
            DATA_OUT <= DATA_IN;
            if (beat == 8'd3) begin
              state <= S_IDLE;
              beat  <= '0;
            end else beat <= beat + 8'd1;
          end
          default: beat <= '0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_stm32_bus_interface.sv
// Directed bench for stm32_bus_interface (RX_CH=2, other parameters default).
module tb_stm32_bus_interface;
  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  DATA_IN = '0;
  logic        DATA_SYNC = 1'b0;
  logic        ADC_OTR = 1'b0;
  logic [31:0] rx_i = '0;
  logic [31:0] rx_q = '0;
  logic        iq_valid = 1'b0;
  logic [3:0]  DATA_OUT;
  logic [21:0] freq_out;
  logic        preamp_enable, rx, tx, audio_clk_en, tx_iq_valid;
  logic signed [15:0] TX_I, TX_Q;
  logic [3:0]  fifo_level;
  logic [7:0]  stage_debug;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] exp_rx [16] = '{4'h0, 4'hA, 4'h0, 4'hB, 4'h0, 4'hC, 4'h0, 4'hD,
                              4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2};
  logic [3:0] exp_getp [7] = '{4'h8, 4'h2, 4'h5, 4'hA, 4'h0, 4'hF, 4'h3};
  logic [3:0] exp_tx [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hF, 4'hE, 4'hD, 4'hC};
  logic [3:0] exp_test [4] = '{4'h5, 4'hA, 4'hF, 4'h3};

  stm32_bus_interface #(.RX_CH(2)) dut (
    .clk_in(clk_in), .reset(reset), .DATA_IN(DATA_IN), .DATA_SYNC(DATA_SYNC),
    .ADC_OTR(ADC_OTR), .rx_i(rx_i), .rx_q(rx_q), .iq_valid(iq_valid),
    .DATA_OUT(DATA_OUT), .freq_out(freq_out), .preamp_enable(preamp_enable),
    .rx(rx), .tx(tx), .audio_clk_en(audio_clk_en), .TX_I(TX_I), .TX_Q(TX_Q),
    .tx_iq_valid(tx_iq_valid), .fifo_level(fifo_level), .stage_debug(stage_debug)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic cmd(input logic [3:0] code);
    DATA_SYNC = 1'b1;
    DATA_IN = code;
    tick();
    DATA_SYNC = 1'b0;
  endtask

  task automatic beat_in(input logic [3:0] v);
    DATA_IN = v;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_data_out", DATA_OUT, 0);
    chk("rst_freq", freq_out, 620407);
    chk("rst_rx", rx, 1);
    chk("rst_tx", tx, 0);
    chk("rst_preamp", preamp_enable, 0);
    chk("rst_audio", audio_clk_en, 0);
    chk("rst_tx_i", TX_I, 0);
    chk("rst_tx_valid", tx_iq_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_stage", stage_debug, 0);

    cmd(4'd2);
    chk("sendp_stage", stage_debug, 8'h20);
    beat_in(4'h0);
    chk("sendp_clean", DATA_OUT, 0);
    chk("sendp_idle", stage_debug, 0);

    cmd(4'd1);
    for (int k = 0; k < 7; k++) begin
      beat_in(exp_getp[k]);
      if (k == 1) chk("getp_stage", stage_debug, 8'h12);
      if (k == 5) chk("getp_atomic", freq_out, 620407);
    end
    chk("getp_freq", freq_out, 22'h25A0F3);
    chk("getp_tx", tx, 1);
    chk("getp_rx", rx, 0);
    chk("getp_preamp", preamp_enable, 0);

    cmd(4'd1);
    beat_in(4'h4); beat_in(4'h1); beat_in(4'h2); beat_in(4'h3);
    cmd(4'd0);
    beat_in(4'h7);
    chk("abort_freq", freq_out, 22'h25A0F3);
    chk("abort_tx", tx, 1);
    chk("abort_preamp", preamp_enable, 0);

    cmd(4'd3);
    for (int k = 0; k < 8; k++) begin
      beat_in(exp_tx[k]);
      if (k == 6) chk("txiq_no_early_valid", tx_iq_valid, 0);
    end
`ifdef STM32_IF_PARITY_EN
    chk("txiq_par_wait", tx_iq_valid, 0);
    beat_in(4'h4);
`endif
    chk("txiq_q", TX_Q, 16'h1234);
    chk("txiq_i", 32'($signed(TX_I)), -32'sd292);
    chk("txiq_valid", tx_iq_valid, 1);
    tick();
    chk("txiq_valid_pulse", tx_iq_valid, 0);

    rx_q = {16'h1111, 16'h0A0B};
    rx_i = {16'h2222, 16'h0C0D};
    iq_valid = 1'b1;
    tick();
    iq_valid = 1'b0;
    chk("push_level", fifo_level, 1);
    cmd(4'd4);
    for (int k = 0; k < 16; k++) begin
      beat_in(4'h0);
      chk($sformatf("rxiq_beat%0d", k), DATA_OUT, exp_rx[k]);
      if (k == 0) chk("pop_level", fifo_level, 0);
    end
`ifdef STM32_IF_PARITY_EN
    beat_in(4'h0);
    chk("rxiq_parity", DATA_OUT, 0);
`endif
    chk("rxiq_idle", stage_debug, 0);
    tick();
    chk("rxiq_hold", DATA_OUT, 4'h2);

    rx_i = '0;
    for (int k = 0; k < 9; k++) begin
      rx_q = {16'h0, 16'(k + 1)};
      iq_valid = 1'b1;
      tick();
    end
    iq_valid = 1'b0;
    chk("full_level", fifo_level, 8);
    cmd(4'd2);
    beat_in(4'h0);
    chk("sendp_overrun", DATA_OUT, 4'h2);
    chk("full_level_hold", fifo_level, 8);
    cmd(4'd2);
    beat_in(4'h0);
    chk("sendp_overrun_clr", DATA_OUT, 4'h0);

    cmd(4'd4);
    iq_valid = 1'b1;
    beat_in(4'h0);
    iq_valid = 1'b0;
    chk("pushpop_full_level", fifo_level, 8);
    for (int k = 1; k < 16; k++) begin
      beat_in(4'h0);
      if (k == 3) chk("fifo_order", DATA_OUT, 4'h1);
    end
    cmd(4'd2);
    beat_in(4'h0);
    chk("pushpop_full_no_ovr", DATA_OUT, 4'h0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset2_level", fifo_level, 0);
    chk("reset2_freq", freq_out, 620407);
    chk("reset2_tx_q", TX_Q, 0);

    cmd(4'd10);
    for (int k = 0; k < 4; k++) begin
      beat_in(exp_test[k]);
      chk($sformatf("test_beat%0d", k), DATA_OUT, exp_test[k]);
    end

    rx_q = {16'h0, 16'h00AB};
    cmd(4'd4);
    iq_valid = 1'b1;
    beat_in(4'h0);
    iq_valid = 1'b0;
    chk("empty_pop_zero", DATA_OUT, 0);
    chk("empty_pushpop_level", fifo_level, 1);
    for (int k = 1; k < 16; k++) begin
      beat_in(4'h0);
      if (k == 3 || k == 15) chk($sformatf("empty_beat%0d", k), DATA_OUT, 0);
    end
    cmd(4'd2);
    beat_in(4'h0);
    chk("sendp_underrun", DATA_OUT, 4'h4);
    cmd(4'd4);
    for (int k = 0; k < 4; k++) beat_in(4'h0);
    chk("stored_after_empty", DATA_OUT, 4'hB);
    chk("stored_level", fifo_level, 0);
    cmd(4'd0);

    ADC_OTR = 1'b1;
    tick();
    ADC_OTR = 1'b0;
    cmd(4'd2);
    ADC_OTR = 1'b1;
    beat_in(4'h0);
    ADC_OTR = 1'b0;
    chk("sendp_otr", DATA_OUT, 4'h1);
    cmd(4'd2);
    beat_in(4'h0);
    chk("sendp_otr_set_wins", DATA_OUT, 4'h1);
    cmd(4'd2);
    beat_in(4'h0);
    chk("sendp_otr_clr", DATA_OUT, 4'h0);

    cmd(4'd5);
    chk("audio_on", audio_clk_en, 1);
    chk("audio_idle", stage_debug, 0);
    cmd(4'd6);
    chk("audio_off", audio_clk_en, 0);

`ifdef STM32_IF_PARITY_EN
    cmd(4'd3);
    for (int k = 0; k < 8; k++) beat_in(4'h7);
    beat_in(4'h5);
    chk("par_bad_hold_q", TX_Q, 0);
    chk("par_bad_no_valid", tx_iq_valid, 0);
    cmd(4'd2);
    beat_in(4'h0);
    chk("sendp_parity", DATA_OUT, 4'h8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
